// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide controller for DIV/DIVU in EX.
// Stalls the pipeline while dividing and delivers quotient (LO) and remainder (HI).
module div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic        stall_req,
  output logic        busy,
  output logic        result_valid,
  output logic        div_by_zero,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        dvd_neg_q, dvd_neg_d;
  logic        dvs_neg_q, dvs_neg_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        dbz_q, dbz_d;

  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] diff;
  logic [64:0] work_step;
  logic [31:0] quot_raw, rem_raw;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] dz_hi;

  // Operand sign handling only applies to DIV; DIVU treats bit 31 as magnitude.
  assign dvd_neg = signed_div & opdata1[31];
  assign dvs_neg = signed_div & opdata2[31];
  assign dvd_mag = dvd_neg ? (~opdata1 + 32'd1) : opdata1;
  assign dvs_mag = dvs_neg ? (~opdata2 + 32'd1) : opdata2;

  // One restoring step: a borrow in diff[32] means the divisor did not fit.
  assign diff      = work_q[64:32] - {1'b0, divisor_q};
  assign work_step = diff[32] ? {work_q[63:0], 1'b0}
                              : {diff[31:0], work_q[31:0], 1'b1};
  assign quot_raw  = work_step[31:0];
  assign rem_raw   = work_step[64:33];
  assign quot_fix  = (dvd_neg_q ^ dvs_neg_q) ? (~quot_raw + 32'd1) : quot_raw;
  assign rem_fix   = dvd_neg_q ? (~rem_raw + 32'd1) : rem_raw;

  // Re-negating the captured magnitude restores the original dividend bits.
  assign dz_hi = dvd_neg_q ? (~work_q[32:1] + 32'd1) : work_q[32:1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    dbz_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !annul) begin
          work_d    = {32'd0, dvd_mag, 1'b0};
          divisor_d = dvs_mag;
          dvd_neg_d = dvd_neg;
          dvs_neg_d = dvs_neg;
          cnt_d     = 6'd0;
          state_d   = (opdata2 == 32'd0) ? ST_DIVZERO : ST_ON;
        end
      end
      ST_ON: begin
        work_d = work_step;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = ST_END;
          lo_d    = quot_fix;
          hi_d    = rem_fix;
        end
      end
      ST_DIVZERO: begin
        state_d = ST_END;
        lo_d    = 32'hFFFF_FFFF;
        hi_d    = dz_hi;
        dbz_d   = 1'b1;
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush wins over everything and must not disturb the visible results.
    if (annul) begin
      state_d = ST_IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      lo_q      <= 32'd0;
      hi_q      <= 32'd0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dbz_q     <= dbz_d;
    end
  end

  // Request cycle stalls combinationally; END releases the instruction from EX.
  assign stall_req    = ((state_q == ST_IDLE) && start && !annul)
                      || (state_q == ST_ON) || (state_q == ST_DIVZERO);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_END);
  assign div_by_zero  = dbz_q;
  assign lo_out       = lo_q;
  assign hi_out       = hi_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: cycle-exact stall/valid timing,
// signed/unsigned results, divide by zero, annul and mid-operation reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        stall_req;
  logic        busy;
  logic        result_valid;
  logic        div_by_zero;
  logic [31:0] lo_out;
  logic [31:0] hi_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  div_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_div   (signed_div),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .annul        (annul),
    .stall_req    (stall_req),
    .busy         (busy),
    .result_valid (result_valid),
    .div_by_zero  (div_by_zero),
    .lo_out       (lo_out),
    .hi_out       (hi_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one divide with start held through the stall; len is the stall length.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic exp_dbz, input int len);
    exp_q.push_back(exp_lo);
    exp_q.push_back(exp_hi);
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      check({tag, " stall"}, 32'(stall_req), 32'(k < len));
      check({tag, " valid"}, 32'(result_valid), 32'(k == len));
      check({tag, " busy"}, 32'(busy), 32'(k > 0));
      if (k < len) begin
        @(posedge clk); #1;
      end
    end
    check({tag, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    check({tag, " lo"}, lo_out, exp_q.pop_front());
    check({tag, " hi"}, hi_out, exp_q.pop_front());
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle valid"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    int valid_seen;
    rst_n = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;

    // Reset state
    @(negedge clk);
    check("rst stall", 32'(stall_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(result_valid), 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    check("rst lo", lo_out, 32'd0);
    check("rst hi", hi_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    do_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    do_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);

    // annul together with start in IDLE drops the request
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
    @(negedge clk);
    check("annul idle stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("annul idle busy", 32'(busy), 32'd0);

    // annul in ON cycle 10
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    annul = 1'b1;
    @(negedge clk);
    check("annul on busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul next busy", 32'(busy), 32'd0);
    check("annul next stall", 32'(stall_req), 32'd0);
    valid_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) valid_seen++;
    end
    check("annul no valid", 32'(valid_seen), 32'd0);
    check("annul lo kept", lo_out, 32'hFFFF_FFFF);
    check("annul hi kept", hi_out, 32'hFFFF_FFFB);
    do_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // reset asserted mid-ON
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst stall", 32'(stall_req), 32'd0);
    check("mid rst valid", 32'(result_valid), 32'd0);
    check("mid rst dbz", 32'(div_by_zero), 32'd0);
    check("mid rst lo", lo_out, 32'd0);
    check("mid rst hi", hi_out, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst busy", 32'(busy), 32'd0);

    // back-to-back: second request sampled in the IDLE cycle after END
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd20; opdata2 = 32'd6;
    for (int k = 0; k <= 67; k++) begin
      @(negedge clk);
      check("b2b valid", 32'(result_valid), 32'((k == 33) || (k == 67)));
      if (k == 33) begin
        check("b2b1 stall", 32'(stall_req), 32'd0);
        check("b2b1 lo", lo_out, 32'd3);
        check("b2b1 hi", hi_out, 32'd2);
      end
      if (k == 34) check("b2b2 req stall", 32'(stall_req), 32'd1);
      if (k == 67) begin
        check("b2b2 lo", lo_out, 32'd4);
        check("b2b2 hi", hi_out, 32'd0);
      end
      @(posedge clk); #1;
      if (k == 33) opdata2 = 32'd5;
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b idle busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide controller for the EX stage. It sequences a radix-2 restoring divider for DIV/DIVU and holds the pipeline stalled while the divide is in progress. It then delivers quotient and remainder for the HI/LO write path. The single-cycle ALU keeps handling all other operations; this block owns only the divide sequence and its stall and annul handshake.

## Interface
- No parameters (width fixed at 32).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  divide request from EX; level, sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1  in  32  dividend (rs); sampled with start.
- opdata2  in  32  divisor (rt); sampled with start.
- annul  in  1  flush; aborts any operation in progress.
- stall_req  out  1  pipeline stall request.
- busy  out  1  1 in any state other than IDLE.
- result_valid  out  1  one-cycle pulse when results are final.
- div_by_zero  out  1  valid with result_valid; divisor was 0.
- lo_out  out  32  quotient (to LO).
- hi_out  out  32  remainder (to HI).

## Operation
- States: IDLE, DIVZERO, ON, END. The state register, 6-bit counter, 65-bit working register and divisor register all reset asynchronously.
- IDLE:
  - start=1 and annul=0 and opdata2≠0 → ON.
  - start=1 and annul=0 and opdata2=0 → DIVZERO.
  - Otherwise stay in IDLE.
- Operand capture on leaving IDLE:
  - If signed_div=1, each negative operand is replaced by its two's-complement magnitude.
  - Original sign bits are latched.
  - Working register loaded as {32'b0, |dividend|, 1'b0}; counter cleared.
- ON, once per cycle:
  - diff = work[64:32] − {1'b0, |divisor|} (33-bit).
  - If diff ≥ 0, work ← {diff[31:0], work[31:0], 1'b1}; otherwise work ← {work[63:0], 1'b0}.
  - Counter increments each cycle; after the 32nd iteration (counter=31) → END.
- Result:
  - Raw quotient = work[31:0]; raw remainder = work[64:33].
  - If signed_div=1: negate the quotient when the operand signs differ; negate the remainder when the dividend was negative.
- Signed overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. There is no trap.
- DIVZERO: one cycle, then END.
  - Results: lo_out=0xFFFFFFFF, hi_out=dividend unmodified, div_by_zero=1.
  - No division iterations are performed.
- END:
  - Exactly one cycle, then IDLE unconditionally.
  - lo_out/hi_out are updated at the edge entering END and hold until the next END.
  - start is ignored in END.
- annul:
  - Has priority over everything. In any state, next state is IDLE.
  - No result_valid; lo_out/hi_out are not updated.
  - annul=1 with start=1 in IDLE: the request is dropped.
- Reset values: state IDLE; stall_req=0, busy=0, result_valid=0, div_by_zero=0, lo_out=0, hi_out=0.

## Timing
- stall_req = (IDLE & start & ~annul) | ON | DIVZERO.
  - stall_req is combinational on start so the request cycle itself stalls.
  - stall_req is 0 in END, so the divide instruction leaves EX at the END clock edge.
- result_valid = (state==END). div_by_zero is registered and valid in the same cycle.
- Normal divide, with the request in cycle 0 (IDLE):
  - ON occupies cycles 1–32.
  - END is cycle 33: result_valid=1, stall_req=0.
  - Total stall: 33 cycles (cycles 0–32).
- Divide by zero: request in cycle 0, DIVZERO in cycle 1, END in cycle 2. Stall: 2 cycles.
- Back-to-back divides: the second start is seen in the IDLE cycle following END. There is no bubble beyond that cycle.
- Reset asserted mid-operation: immediate return to IDLE, all outputs at reset values, no result_valid.

## Test plan
- DIVU 100 / 7, start held through the stall → stall_req high in cycles 0–32; result_valid only in cycle 33 with lo=14, hi=2; busy low in cycle 34.
- DIV −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIV 7 / −2 → lo=−3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- DIVU 5 / 0 → result_valid in cycle 2 with div_by_zero=1, lo=0xFFFFFFFF, hi=5; stall_req high only in cycles 0–1.
- annul pulsed in ON cycle 10 → IDLE next cycle; no result_valid; lo/hi keep the previous result; a new DIVU 9 / 3 then gives lo=3, hi=0.
- rst_n driven low mid-ON, then released, then two back-to-back DIVU (20/6, 20/5) → all outputs 0 during reset; results 3 r 2 in the first END and 4 r 0 in the second END, 34 cycles apart.
